// File: rtl/alu_pkt_core_if.sv
// -----------------------------------------------------------------------------
// alu_pkt_if
// Operation/result bundle for alu_pkt_core.
//   valid_in, cin, a[3:0], b[3:0], ctl[3:0] : operation request (master drives)
//   valid_out, carry, zero, alu[3:0], pkt_num[4:0] : tagged result (slave drives)
// master = stimulus side, slave = the ALU core.
// -----------------------------------------------------------------------------
interface alu_pkt_if;
    logic       valid_in;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ctl;
    logic       valid_out;
    logic       carry;
    logic       zero;
    logic [3:0] alu;
    logic [4:0] pkt_num;

    modport master (
        output valid_in, cin, a, b, ctl,
        input  valid_out, carry, zero, alu, pkt_num
    );

    modport slave (
        input  valid_in, cin, a, b, ctl,
        output valid_out, carry, zero, alu, pkt_num
    );
endinterface

// File: rtl/alu_pkt_core.sv
// -----------------------------------------------------------------------------
// alu_pkt_core
// Two-stage pipelined 4-bit ALU. Stage 1 captures an operation and tags it
// with a 5-bit packet number; stage 2 computes and registers the result,
// carry and zero flags. One operation per cycle, no backpressure.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; flushes both stages, zeroes outputs
//   bus   : alu_pkt_if.slave (operation in, tagged result out)
// -----------------------------------------------------------------------------
module alu_pkt_core (
    input  logic       clk,
    input  logic       reset,
    alu_pkt_if.slave   bus
);

    // Stage 1 registers
    logic       r_s1_valid;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_cin;
    logic [3:0] r_ctl;
    logic [4:0] r_s1_pkt;
    logic [4:0] r_pkt_cnt;

    // Stage 2 (output) registers
    logic       r_valid_out;
    logic       r_carry;
    logic       r_zero;
    logic [3:0] r_alu;
    logic [4:0] r_pkt_num;

    // Combinational result: {carry, alu}
    logic [4:0] w_res;
    logic       w_zero;

    // Stage 1: operand registers only load on a valid operation, so idle-cycle
    // operand changes never reach the datapath. The 5-bit counter wraps 31->0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_a        <= 4'h0;
            r_b        <= 4'h0;
            r_cin      <= 1'b0;
            r_ctl      <= 4'h0;
            r_s1_pkt   <= 5'd0;
            r_pkt_cnt  <= 5'd0;
        end else begin
            r_s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                r_a       <= bus.a;
                r_b       <= bus.b;
                r_cin     <= bus.cin;
                r_ctl     <= bus.ctl;
                r_s1_pkt  <= r_pkt_cnt;
                r_pkt_cnt <= r_pkt_cnt + 5'd1;
            end
        end
    end

    // Arithmetic runs in 5 bits on zero-extended operands, so bit 4 is the
    // carry for additions and the borrow for subtractions.
    always_comb begin
        w_res = 5'd0;
        case (r_ctl)
            4'd0:    w_res = {1'b0, r_a};
            4'd1:    w_res = {1'b0, r_a} + 5'd1;
            4'd2:    w_res = {1'b0, r_a} - 5'd1;
            4'd3:    w_res = {1'b0, r_a} + {1'b0, r_b};
            4'd4:    w_res = {1'b0, r_a} + {1'b0, r_b} + {4'b0, r_cin};
            4'd5:    w_res = {1'b0, r_a} - {1'b0, r_b};
            4'd6:    w_res = {1'b0, r_a} - {1'b0, r_b} - {4'b0, r_cin};
            4'd7:    w_res = {1'b0, r_a & r_b};
            4'd8:    w_res = {1'b0, r_a | r_b};
            4'd9:    w_res = {1'b0, r_a ^ r_b};
            4'd10:   w_res = {1'b0, ~r_a};
            4'd11:   w_res = {r_a[3], r_a[2:0], 1'b0};
            4'd12:   w_res = {r_a[0], 1'b0, r_a[3:1]};
            4'd13:   w_res = {r_a[3], r_a[2:0], r_cin};
            4'd14:   w_res = {r_a[0], r_cin, r_a[3:1]};
            default: w_res = 5'd0;
        endcase
        // Zero looks only at the 4-bit result, never at the carry.
        w_zero = (w_res[3:0] == 4'h0);
    end

    // Stage 2: result registers hold their last values on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_alu       <= 4'h0;
            r_pkt_num   <= 5'd0;
        end else begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_carry   <= w_res[4];
                r_zero    <= w_zero;
                r_alu     <= w_res[3:0];
                r_pkt_num <= r_s1_pkt;
            end
        end
    end

    assign bus.valid_out = r_valid_out;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.alu       = r_alu;
    assign bus.pkt_num   = r_pkt_num;

endmodule

// File: tb/tb_alu_pkt_core.sv
// -----------------------------------------------------------------------------
// tb_alu_pkt_core
// Directed, table-driven bench for alu_pkt_core. Each table record holds an
// operation and its hand-computed alu/carry/zero. Sequences of valid/idle
// slots are driven on falling edges; slot t is checked two falling edges
// later, with pkt_num expected to count accepted operations from 0.
// -----------------------------------------------------------------------------
module tb_alu_pkt_core;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] ctl;
        logic [3:0] e_alu;
        logic       e_carry;
        logic       e_zero;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    alu_pkt_if bus ();

    alu_pkt_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    vec_t       vt [0:19];
    bit         sv [0:63];   // slot carries an operation
    int         si [0:63];   // table index for that slot
    int         n_chk = 0;
    int         n_err = 0;
    logic [4:0] exp_pkt;
    logic [3:0] h_alu;
    logic       h_carry;
    logic       h_zero;
    logic [4:0] h_pkt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid_out"}, 32'(bus.valid_out), 32'd0);
        chk({tag, " carry"},     32'(bus.carry),     32'd0);
        chk({tag, " zero"},      32'(bus.zero),      32'd0);
        chk({tag, " alu"},       32'(bus.alu),       32'd0);
        chk({tag, " pkt_num"},   32'(bus.pkt_num),   32'd0);
    endtask

    task automatic clear_model();
        exp_pkt = 5'd0;
        h_alu   = 4'h0;
        h_carry = 1'b0;
        h_zero  = 1'b0;
        h_pkt   = 5'd0;
    endtask

    task automatic drive_idle();
        bus.valid_in = 1'b0;
        bus.a        = 4'($urandom);
        bus.b        = 4'($urandom);
        bus.cin      = 1'($urandom);
        bus.ctl      = 4'($urandom);
    endtask

    // Drives len slots from sv/si; if rel, reset is released on the first
    // falling edge so the first slot is sampled on the first edge after release.
    task automatic run_seq(input string tag, input int len, input bit rel);
        logic [4:0] ep [0:63];
        int s;
        for (int t = 0; t < len + 2; t++) begin
            @(negedge clk);
            if (t >= 2) begin
                s = t - 2;
                if (sv[s]) begin
                    h_alu   = vt[si[s]].e_alu;
                    h_carry = vt[si[s]].e_carry;
                    h_zero  = vt[si[s]].e_zero;
                    h_pkt   = ep[s];
                end
                chk($sformatf("%s[%0d] valid_out", tag, s), 32'(bus.valid_out), 32'(sv[s]));
                chk($sformatf("%s[%0d] alu", tag, s),       32'(bus.alu),       32'(h_alu));
                chk($sformatf("%s[%0d] carry", tag, s),     32'(bus.carry),     32'(h_carry));
                chk($sformatf("%s[%0d] zero", tag, s),      32'(bus.zero),      32'(h_zero));
                chk($sformatf("%s[%0d] pkt_num", tag, s),   32'(bus.pkt_num),   32'(h_pkt));
                $display("%s slot %0d: valid_out=%0b alu=%h carry=%0b zero=%0b pkt=%0d",
                         tag, s, bus.valid_out, bus.alu, bus.carry, bus.zero, bus.pkt_num);
            end
            if (t < len && sv[t]) begin
                bus.valid_in = 1'b1;
                bus.a        = vt[si[t]].a;
                bus.b        = vt[si[t]].b;
                bus.cin      = vt[si[t]].cin;
                bus.ctl      = vt[si[t]].ctl;
                ep[t]        = exp_pkt;
                exp_pkt      = exp_pkt + 5'd1;
            end else begin
                drive_idle();
            end
            if (rel && t == 0) reset = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          a     b     cin   ctl    alu   carry zero
        vt[0]  = '{4'h3, 4'h4, 1'b0, 4'd3,  4'h7, 1'b0, 1'b0};
        vt[1]  = '{4'hF, 4'h1, 1'b0, 4'd3,  4'h0, 1'b1, 1'b1};
        vt[2]  = '{4'h2, 4'h5, 1'b0, 4'd5,  4'hD, 1'b1, 1'b0};
        vt[3]  = '{4'h5, 4'h4, 1'b1, 4'd6,  4'h0, 1'b0, 1'b1};
        vt[4]  = '{4'h9, 4'h0, 1'b0, 4'd13, 4'h2, 1'b1, 1'b0};
        vt[5]  = '{4'h9, 4'h0, 1'b1, 4'd14, 4'hC, 1'b1, 1'b0};
        vt[6]  = '{4'h7, 4'h3, 1'b1, 4'd15, 4'h0, 1'b0, 1'b1};
        vt[7]  = '{4'h6, 4'h0, 1'b0, 4'd0,  4'h6, 1'b0, 1'b0};
        vt[8]  = '{4'hF, 4'h0, 1'b0, 4'd1,  4'h0, 1'b1, 1'b1};
        vt[9]  = '{4'h0, 4'h0, 1'b0, 4'd2,  4'hF, 1'b1, 1'b0};
        vt[10] = '{4'h7, 4'h8, 1'b1, 4'd4,  4'h0, 1'b1, 1'b1};
        vt[11] = '{4'h2, 4'h3, 1'b0, 4'd4,  4'h5, 1'b0, 1'b0};
        vt[12] = '{4'h0, 4'h0, 1'b1, 4'd6,  4'hF, 1'b1, 1'b0};
        vt[13] = '{4'hC, 4'hA, 1'b0, 4'd7,  4'h8, 1'b0, 1'b0};
        vt[14] = '{4'hC, 4'h3, 1'b0, 4'd8,  4'hF, 1'b0, 1'b0};
        vt[15] = '{4'hF, 4'h5, 1'b0, 4'd9,  4'hA, 1'b0, 1'b0};
        vt[16] = '{4'h5, 4'h0, 1'b0, 4'd10, 4'hA, 1'b0, 1'b0};
        vt[17] = '{4'h9, 4'h0, 1'b0, 4'd11, 4'h2, 1'b1, 1'b0};
        vt[18] = '{4'h9, 4'h0, 1'b0, 4'd12, 4'h4, 1'b1, 1'b0};
        vt[19] = '{4'hF, 4'h0, 1'b0, 4'd10, 4'h0, 1'b0, 1'b1};

        // Reset held with a valid operation presented: outputs must stay 0.
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        bus.a        = 4'hF;
        bus.b        = 4'h1;
        bus.cin      = 1'b1;
        bus.ctl      = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        $display("reset: valid_out=%0b alu=%h carry=%0b zero=%0b pkt=%0d",
                 bus.valid_out, bus.alu, bus.carry, bus.zero, bus.pkt_num);

        // 34 back-to-back operations cycling the table: every ctl value,
        // first-op check (3+4) and pkt_num wrap 31 -> 0 -> 1.
        clear_model();
        for (int i = 0; i < 34; i++) begin
            sv[i] = 1'b1;
            si[i] = i % 20;
        end
        run_seq("stream", 34, 1'b1);

        // Gap pattern 1,0,0,1,1 after a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        chk_zero("reset2");
        clear_model();
        sv[0] = 1'b1; si[0] = 7;
        sv[1] = 1'b0; si[1] = 0;
        sv[2] = 1'b0; si[2] = 0;
        sv[3] = 1'b1; si[3] = 16;
        sv[4] = 1'b1; si[4] = 2;
        run_seq("gap", 5, 1'b1);

        // Two operations in flight, then an asynchronous reset between edges.
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.a = vt[5].a; bus.b = vt[5].b; bus.cin = vt[5].cin; bus.ctl = vt[5].ctl;
        @(negedge clk);
        bus.a = vt[4].a; bus.b = vt[4].b; bus.cin = vt[4].cin; bus.ctl = vt[4].ctl;
        #2;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        chk_zero("async_rst");
        $display("async reset: valid_out=%0b alu=%h carry=%0b zero=%0b pkt=%0d",
                 bus.valid_out, bus.alu, bus.carry, bus.zero, bus.pkt_num);
        @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");

        // After release: no stale pulses, then the next op is packet 0.
        clear_model();
        sv[0] = 1'b0; sv[1] = 1'b0; sv[2] = 1'b0;
        run_seq("post_rst_idle", 3, 1'b1);
        sv[0] = 1'b1; si[0] = 0;
        run_seq("post_rst_op", 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
